// File: rtl/hack_alu.sv
// 16-bit Hack ALU: six control bits shape x and y, then add or AND, then optionally invert.
// Combinational result and flags, plus a registered copy for pipelined consumers.
module hack_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng,
    output logic [15:0] out_r,
    output logic        zr_r,
    output logic        ng_r
);

    logic [15:0] x_zero;
    logic [15:0] x_pre;
    logic [15:0] y_zero;
    logic [15:0] y_pre;
    logic [15:0] result;

    // Zeroing always precedes negation; output inversion is the last stage.
    always_comb begin
        x_zero = zx ? 16'h0000 : x;
        x_pre  = nx ? ~x_zero : x_zero;
        y_zero = zy ? 16'h0000 : y;
        y_pre  = ny ? ~y_zero : y_zero;
        result = f ? (x_pre + y_pre) : (x_pre & y_pre);
        out    = no ? ~result : result;
        zr     = (out == 16'h0000);
        ng     = out[15];
    end

    // No handshake: inputs are sampled every rising edge. Reset leaves flags consistent with a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r <= 16'h0000;
            zr_r  <= 1'b1;
            ng_r  <= 1'b0;
        end else begin
            out_r <= out;
            zr_r  <= zr;
            ng_r  <= ng;
        end
    end

endmodule

// File: tb/tb_hack_alu.sv
// Self-checking bench for hack_alu: directed function-table cases, wrap and reset checks,
// then a randomized sweep of the 18 named functions against an arithmetic reference.
module tb_hack_alu;

    logic        clk;
    logic        rst;
    logic [15:0] x;
    logic [15:0] y;
    logic        zx, nx, zy, ny, f, no;
    logic [15:0] out;
    logic        zr, ng;
    logic [15:0] out_r;
    logic        zr_r, ng_r;

    int total = 0;
    int bad   = 0;

    logic [5:0] codes [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
    };

    hack_alu dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .out(out), .zr(zr), .ng(ng),
        .out_r(out_r), .zr_r(zr_r), .ng_r(ng_r)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: what each named function means, in plain arithmetic.
    function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        case (c)
            6'b101010: ref_alu = 16'd0;
            6'b111111: ref_alu = 16'd1;
            6'b111010: ref_alu = 16'hFFFF;
            6'b001100: ref_alu = a;
            6'b110000: ref_alu = b;
            6'b001101: ref_alu = ~a;
            6'b110001: ref_alu = ~b;
            6'b001111: ref_alu = 16'd0 - a;
            6'b110011: ref_alu = 16'd0 - b;
            6'b011111: ref_alu = a + 16'd1;
            6'b110111: ref_alu = b + 16'd1;
            6'b001110: ref_alu = a - 16'd1;
            6'b110010: ref_alu = b - 16'd1;
            6'b000010: ref_alu = a + b;
            6'b010011: ref_alu = a - b;
            6'b000111: ref_alu = b - a;
            6'b000000: ref_alu = a & b;
            6'b010101: ref_alu = a | b;
            default:   ref_alu = 16'hXXXX;
        endcase
    endfunction

    // driver tasks
    task automatic drive(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        {zx, nx, zy, ny, f, no} = c;
        x = a;
        y = b;
        #1;
    endtask

    // scoreboard
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag, input logic [15:0] exp);
        chk({tag, "_out"}, out, exp);
        chk({tag, "_zr"}, {15'd0, zr}, {15'd0, exp == 16'h0000});
        chk({tag, "_ng"}, {15'd0, ng}, {15'd0, exp[15]});
    endtask

    task automatic chk_reg(input string tag, input logic [15:0] exp);
        chk({tag, "_out_r"}, out_r, exp);
        chk({tag, "_zr_r"}, {15'd0, zr_r}, {15'd0, exp == 16'h0000});
        chk({tag, "_ng_r"}, {15'd0, ng_r}, {15'd0, exp[15]});
    endtask

    initial begin
        logic [15:0] rx, ry;
        logic [15:0] exp_q [$];
        logic [5:0]  c;

        rst = 1'b1;
        drive(6'b101010, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        chk_reg("reset", 16'h0000);

        @(negedge clk);
        rst = 1'b0;

        // constants with random operands
        rx = 16'($urandom);
        ry = 16'($urandom);
        drive(6'b101010, rx, ry); chk_comb("const0", 16'h0000);
        drive(6'b111111, rx, ry); chk_comb("const1", 16'h0001);
        drive(6'b111010, rx, ry); chk_comb("constm1", 16'hFFFF);

        // pass-through / negation
        drive(6'b001100, 16'h1234, 16'h8001); chk_comb("pass_x", 16'h1234);
        drive(6'b110001, 16'h1234, 16'h8001); chk_comb("not_y", 16'h7FFE);
        drive(6'b001111, 16'h1234, 16'h8001); chk_comb("neg_x", 16'hEDCC);

        // arithmetic
        drive(6'b000010, 16'd5, 16'd7);       chk_comb("x_plus_y", 16'd12);
        drive(6'b010011, 16'd5, 16'd7);       chk_comb("x_minus_y", 16'hFFFE);
        drive(6'b000111, 16'd5, 16'd7);       chk_comb("y_minus_x", 16'd2);
        drive(6'b011111, 16'hFFFF, 16'd7);    chk_comb("inc_to_zero", 16'h0000);

        // logic
        drive(6'b000000, 16'hF0F0, 16'h0FF0); chk_comb("and", 16'h00F0);
        drive(6'b010101, 16'hF0F0, 16'h0FF0); chk_comb("or", 16'hFFF0);

        // wrap
        drive(6'b011111, 16'h7FFF, 16'h0000); chk_comb("wrap_inc", 16'h8000);
        drive(6'b001111, 16'h8000, 16'h0000); chk_comb("wrap_neg", 16'h8000);

        // registered path, then asynchronous reset mid-cycle
        @(negedge clk);
        drive(6'b110111, 16'h0000, 16'h0010);
        @(posedge clk);
        #1;
        chk_reg("reg_y_inc", 16'h0011);
        #1;
        rst = 1'b1;
        #1;
        chk_reg("async_rst", 16'h0000);
        chk_comb("comb_in_rst", 16'h0011);
        @(negedge clk);
        rst = 1'b0;
        drive(6'b000010, 16'd5, 16'd7);
        @(posedge clk);
        #1;
        chk_reg("after_rst", 16'd12);

        // randomized sweep over the named functions
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            c  = codes[$urandom_range(0, 17)];
            rx = 16'($urandom);
            ry = 16'($urandom);
            drive(c, rx, ry);
            exp_q.push_back(ref_alu(c, rx, ry));
            chk_comb($sformatf("rand%0d_c%b", i, c), exp_q[$]);
            @(posedge clk);
            #1;
            chk_reg($sformatf("rand%0d_c%b", i, c), exp_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_alu.md
# hack_alu

16-bit Hack-style arithmetic/logic unit for the CPU datapath. Six control bits (zx, nx, zy, ny, f, no) select among the standard Hack functions of two's-complement operands x and y. The block produces a combinational result with zero (zr) and negative (ng) flags, plus a registered copy of result and flags for pipelined consumers.

## Interface
- No parameters; data width fixed at 16 bits.
- clk  input  1  single clock; registered outputs update on rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  16  operand X, signed two's complement.
- y  input  16  operand Y, signed two's complement.
- zx  input  1  zero X: x' = 0.
- nx  input  1  negate X: x'' = ~x' (bitwise).
- zy  input  1  zero Y: y' = 0.
- ny  input  1  negate Y: y'' = ~y' (bitwise).
- f  input  1  function: 1 -> x'' + y'' (mod 2^16), 0 -> x'' & y''.
- no  input  1  negate output: out = ~result when 1.
- out  output  16  combinational result, signed.
- zr  output  1  combinational: 1 iff out == 0.
- ng  output  1  combinational: equals out[15].
- out_r  output  16  registered out.
- zr_r  output  1  registered zr.
- ng_r  output  1  registered ng.

## Operation
- Pipeline of stages, all combinational: zx then nx on X; zy then ny on Y; f selects 16-bit add (carry out discarded) or bitwise AND; no applies bitwise NOT to result.
- Order fixed: zeroing before negation; output negation last.
- Flags derived from final out only: zr = (out == 16'h0000), ng = out[15]. No carry/overflow flag.
- Required function table (zx nx zy ny f no -> out):
  - 101010 -> 0; 111111 -> 1; 111010 -> -1
  - 001100 -> x; 110000 -> y; 001101 -> ~x; 110001 -> ~y
  - 001111 -> -x; 110011 -> -y
  - 011111 -> x+1; 110111 -> y+1; 001110 -> x-1; 110010 -> y-1
  - 000010 -> x+y; 010011 -> x-y; 000111 -> y-x
  - 000000 -> x&y; 010101 -> x|y
- All 64 control combinations are legal and yield the datapath formula above; no illegal-code handling.
- Arithmetic wraps modulo 2^16 (e.g. 0x7FFF+1 = 0x8000, ng=1; -(0x8000) = 0x8000).
- Registered path: on each rising clk, out_r<=out, zr_r<=zr, ng_r<=ng. No enable.

## Timing
- out, zr, ng: zero latency, purely combinational from x, y and control bits; unaffected by clk and rst.
- out_r, zr_r, ng_r: one-cycle latency from inputs to registered outputs.
- Reset: rst high immediately (asynchronously) forces out_r=0x0000, zr_r=1, ng_r=0 (flags consistent with zero result); held while rst high.
- Reset deasserted: first rising edge after release captures current combinational values.
- Reset mid-operation: registered values lost; combinational outputs continue tracking inputs.
- No handshake; inputs assumed stable before clock edge.

## Test plan
- Constants: random x,y; controls 101010, 111111, 111010 -> out 0/1/-1, zr 1/0/0, ng 0/0/1.
- Pass-through/negation: x=0x1234,y=0x8001; 001100 -> 0x1234 ng0; 110001 -> 0x7FFE ng0; 001111 -> 0xEDCC ng1; all zr=0.
- Arithmetic: x=5,y=7; 000010 -> 12; 010011 -> -2 (0xFFFE, ng1); 000111 -> 2; x=0xFFFF 011111 -> 0 with zr=1.
- Logic: x=0xF0F0,y=0x0FF0; 000000 -> 0x00F0; 010101 -> 0xFFF0 ng1.
- Wrap: x=0x7FFF 011111 -> 0x8000 ng1; x=0x8000 001111 -> 0x8000.
- Registers/reset: assert rst asynchronously mid-cycle -> out_r=0, zr_r=1, ng_r=0 immediately; release, apply x+y=12 -> out_r=12 after next rising edge, zr_r=0; randomized 100-iteration sweep comparing all 18 functions against model.
